// File: rtl/mem_access_pkg.sv
// Shared types and constants for the byte-serial memory access sequencer.
// Beat counts and start-address rules live here so the top stays datapath-only.
package mem_access_pkg;

  localparam int ADDR_W       = 10;
  localparam int BEATS_BYTE   = 1;
  localparam int BEATS_WORD   = 4;
  localparam int BEATS_DOUBLE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A byte access wins when both size flags are set.
  function automatic logic [3:0] beat_count(input logic is_byte, input logic is_double);
    if (is_byte)        return 4'(BEATS_BYTE);
    else if (is_double) return 4'(BEATS_DOUBLE);
    else                return 4'(BEATS_WORD);
  endfunction

  // Wraps modulo 1024 through the natural ADDR_W-bit arithmetic.
  function automatic logic [ADDR_W-1:0] start_addr(input logic is_byte, input logic is_double,
                                                   input logic [ADDR_W-1:0] base);
    if (is_byte)        return base + ADDR_W'(3);
    else if (is_double) return base - ADDR_W'(4);
    else                return base;
  endfunction

endpackage

// File: rtl/mem_access_sequencer.sv
// Splits byte/word/double MEM-stage accesses into one-byte memory beats,
// stalling the pipeline until the response pulse.
//
// state | meaning
// IDLE  | ready; accepts and latches a request
// ISSUE | one memory strobe per cycle, MSB-first
// DRAIN | collect the final read byte of a load
// DONE  | one-cycle rsp_valid; pipeline released
module mem_access_sequencer
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_double,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              stall
);

  state_t            state, state_nxt;
  logic              wr_q;
  logic [3:0]        beats_left;
  logic [63:0]       wd_q;
  logic [63:0]       wd_aligned;
  logic [63:0]       result;
  logic              rd_pend;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              last_beat;

  assign accept    = (state == IDLE) && req_valid;
  assign last_beat = (beats_left == 4'd0);
  assign mem_addr  = addr_q;

  // Left-align the active bytes so every beat sends wd_q[63:56].
  always_comb begin
    wd_aligned = req_wdata;
    if (req_byte)        wd_aligned = {req_wdata[7:0], 56'h0};
    else if (!req_double) wd_aligned = {req_wdata[31:0], 32'h0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'h00;
    rsp_valid = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          stall     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        stall     = 1'b1;
        mem_we    = wr_q;
        mem_re    = !wr_q;
        mem_wdata = wr_q ? wd_q[63:56] : 8'h00;
        if (last_beat) state_nxt = wr_q ? DONE : DRAIN;
      end
      DRAIN: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b0;
      beats_left <= 4'd0;
      wd_q       <= 64'h0;
      result     <= 64'h0;
      rd_pend    <= 1'b0;
      addr_q     <= '0;
      rsp_rdata  <= 64'h0;
    end else if (accept) begin
      wr_q       <= req_write;
      beats_left <= beat_count(req_byte, req_double) - 4'd1;
      wd_q       <= wd_aligned;
      result     <= 64'h0;
      rd_pend    <= 1'b0;
      addr_q     <= start_addr(req_byte, req_double, req_addr);
    end else begin
      // Read data lags its strobe by one cycle, so the shift follows rd_pend.
      rd_pend <= mem_re;
      if (rd_pend) result <= {result[55:0], mem_rdata};
      if (state == ISSUE && !last_beat) begin
        beats_left <= beats_left - 4'd1;
        addr_q     <= addr_q + ADDR_W'(1);
        wd_q       <= {wd_q[55:0], 8'h00};
      end
      if (state == ISSUE && last_beat && wr_q) rsp_rdata <= 64'h0;
      if (state == DRAIN)                      rsp_rdata <= {result[55:0], mem_rdata};
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed table, reset abort,
// and randomized accesses against a byte-array reference model.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_double;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        stall;

  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [7:0]  pl_data;

  logic [7:0]  mem_byte_model [1024];
  logic [7:0]  ref_mem [1024];

  int n_chk;
  int n_fail;

  mem_access_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_double(req_double), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1024x8 memory with one-cycle read; pl_* is a preload port.
  always @(posedge clk) begin
    if (pl_en)       mem_byte_model[pl_addr] <= pl_data;
    else if (mem_we) mem_byte_model[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_byte_model[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic int m_beats(input bit byt, input bit dbl);
    return byt ? 1 : (dbl ? 8 : 4);
  endfunction

  function automatic int m_start(input bit byt, input bit dbl, input int addr);
    int off;
    off = byt ? 3 : (dbl ? -4 : 0);
    return (addr + off + 1024) % 1024;
  endfunction

  function automatic int m_lat(input bit wr, input int n);
    return wr ? n + 1 : n + 2;
  endfunction

  task automatic do_access(input bit wr, input bit byt, input bit dbl, input logic [9:0] addr,
                           input logic [63:0] wdata, input int exp_start, input int exp_beats,
                           input int exp_lat, input bit chk_rd, input logic [63:0] exp_rd,
                           input bit hold, input string tag);
    int          n;
    int          start;
    int          waitc;
    int          rsp_c;
    logic [63:0] mdl_rd;
    logic [63:0] rsp_d;
    logic [63:0] tmp;
    int          q_addr[$];
    logic [7:0]  q_data[$];
    bit          q_we[$];
    n      = m_beats(byt, dbl);
    start  = m_start(byt, dbl, int'(addr));
    mdl_rd = 64'h0;
    if (!wr) for (int i = 0; i < n; i++) mdl_rd = (mdl_rd << 8) | 64'(ref_mem[(start + i) % 1024]);
    rsp_d  = 64'h0;
    req_write = wr; req_byte = byt; req_double = dbl; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    if (!req_ready) check({tag, "_stall_in_done"}, stall, 1'b0);
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      timeout_fail({tag, "_accept"});
      req_valid = 1'b0;
      return;
    end
    check({tag, "_stall_accept"}, stall, 1'b1);
    @(posedge clk);
    rsp_c = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_byte   = 1'($urandom);
        req_double = 1'($urandom);
        req_addr   = 10'($urandom);
        req_wdata  = {$urandom, $urandom};
      end
      if (mem_we || mem_re) begin
        q_addr.push_back(int'(mem_addr));
        q_data.push_back(mem_wdata);
        q_we.push_back(mem_we);
      end
      check({tag, "_stall"}, stall, 1'(c < exp_lat));
      if (rsp_valid) begin
        rsp_c = c;
        rsp_d = rsp_rdata;
        break;
      end
    end
    if (rsp_c == 0) timeout_fail({tag, "_rsp"});
    check({tag, "_rsp_cycle"}, 64'(rsp_c), 64'(exp_lat));
    check({tag, "_nbeats"}, 64'(q_addr.size()), 64'(exp_beats));
    for (int i = 0; i < q_addr.size() && i < n; i++) begin
      tmp = wdata >> (8 * (n - 1 - i));
      check($sformatf("%s_addr%0d", tag, i), 64'(q_addr[i]), 64'((exp_start + i) % 1024));
      check($sformatf("%s_dir%0d", tag, i), 64'(q_we[i]), 64'(wr));
      check($sformatf("%s_wdata%0d", tag, i), 64'(q_data[i]), wr ? 64'(tmp[7:0]) : 64'h0);
    end
    check({tag, "_rdata"}, rsp_d, wr ? 64'h0 : mdl_rd);
    if (chk_rd) check({tag, "_rdata_tbl"}, rsp_d, exp_rd);
    if (wr) for (int i = 0; i < n; i++) begin
      tmp = wdata >> (8 * (n - 1 - i));
      ref_mem[(start + i) % 1024] = tmp[7:0];
    end
    if (hold) begin
      @(negedge clk);
      check({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
      check({tag, "_rsp_hold"}, rsp_rdata, rsp_d);
      check({tag, "_ready_after"}, req_ready, 1'b1);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          byt;
    bit          dbl;
    logic [9:0]  addr;
    logic [63:0] wdata;
    int          exp_start;
    int          exp_beats;
    int          exp_lat;
    bit          chk_rd;
    logic [63:0] exp_rd;
    bit          hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit          wr, byt, dbl;
    logic [9:0]  a;
    logic [63:0] w;
    logic [63:0] rw;
    int          nb;
    int          strobes;
    int          pulses;

    n_chk = 0; n_fail = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_double = 1'b0;
    req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    vecs[0] = '{wr:0, byt:0, dbl:0, addr:10'h010, wdata:64'h0, exp_start:16, exp_beats:4,
                exp_lat:6, chk_rd:1, exp_rd:64'h14, hold:1};
    vecs[1] = '{wr:1, byt:0, dbl:1, addr:10'h008, wdata:64'h0102030405060708, exp_start:4,
                exp_beats:8, exp_lat:9, chk_rd:1, exp_rd:64'h0, hold:1};
    vecs[2] = '{wr:0, byt:1, dbl:1, addr:10'h3FC, wdata:64'h0, exp_start:1023, exp_beats:1,
                exp_lat:3, chk_rd:1, exp_rd:64'hAB, hold:1};
    vecs[3] = '{wr:0, byt:0, dbl:1, addr:10'h002, wdata:64'h0, exp_start:1022, exp_beats:8,
                exp_lat:10, chk_rd:0, exp_rd:64'h0, hold:1};
    vecs[4] = '{wr:1, byt:0, dbl:0, addr:10'h200, wdata:64'hDEADBEEFCAFEF00D, exp_start:512,
                exp_beats:4, exp_lat:5, chk_rd:1, exp_rd:64'h0, hold:0};
    vecs[5] = '{wr:0, byt:0, dbl:0, addr:10'h200, wdata:64'h0, exp_start:512, exp_beats:4,
                exp_lat:6, chk_rd:1, exp_rd:64'hCAFEF00D, hold:1};

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 10'(i);
      if (i == 19)                 pl_data = 8'h14;
      else if (i >= 16 && i <= 18) pl_data = 8'h00;
      else if (i == 1023)          pl_data = 8'hAB;
      else                         pl_data = 8'($urandom);
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_mem_addr", mem_addr, 10'h000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 64'h0);
    check("rst_stall", stall, 1'b0);
    req_valid = 1'b1;
    #1;
    check("rst_stall_comb", stall, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_access(vecs[i].wr, vecs[i].byt, vecs[i].dbl, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_start, vecs[i].exp_beats, vecs[i].exp_lat, vecs[i].chk_rd,
                vecs[i].exp_rd, vecs[i].hold, $sformatf("vec%0d", i));

    // Reset during the third beat of a double store.
    rw = 64'h1122334455667788;
    req_write = 1'b1; req_byte = 1'b0; req_double = 1'b1; req_addr = 10'h100; req_wdata = rw;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_b1_addr", mem_addr, 10'h0FC);
    @(negedge clk);
    @(negedge clk);
    check("abort_b3_we", mem_we, 1'b1);
    check("abort_b3_addr", mem_addr, 10'h0FE);
    rst = 1'b1;
    #1;
    check("abort_we_now", mem_we, 1'b0);
    check("abort_ready_now", req_ready, 1'b1);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_next", req_ready, 1'b1);
    strobes = 0; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_we || mem_re) strobes++;
      if (rsp_valid) pulses++;
      @(negedge clk);
    end
    check("abort_no_strobes", 64'(strobes), 64'h0);
    check("abort_no_rsp", 64'(pulses), 64'h0);
    ref_mem[10'h0FC] = rw[63:56];
    ref_mem[10'h0FD] = rw[55:48];
    do_access(1'b0, 1'b0, 1'b1, 10'h100, 64'h0, 252, 8, 10, 1'b0, 64'h0, 1'b1, "abort_readback");

    for (int k = 0; k < 40; k++) begin
      wr  = 1'($urandom);
      byt = 1'($urandom);
      dbl = 1'($urandom);
      a   = 10'($urandom);
      w   = {$urandom, $urandom};
      nb  = m_beats(byt, dbl);
      do_access(wr, byt, dbl, a, w, m_start(byt, dbl, int'(a)), nb, m_lat(wr, nb),
                1'b0, 64'h0, 1'($urandom), $sformatf("rnd%0d", k));
    end
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: MEM stage presents an access.
REQ-004 SHALL have port req_ready, output, 1 bit: sequencer idle and accepting.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_byte, input, 1 bit: byte access; takes priority over req_double.
REQ-007 SHALL have port req_double, input, 1 bit: 64-bit access; when req_byte and req_double are both 0, the access is a 32-bit word.
REQ-008 SHALL have port req_addr, input, 10 bits: base byte address.
REQ-009 SHALL have port req_wdata, input, 64 bits: store data, right-aligned.
REQ-010 SHALL have port mem_addr, output, 10 bits: byte address to memory.
REQ-011 SHALL have port mem_we, output, 1 bit: byte write strobe.
REQ-012 SHALL have port mem_re, output, 1 bit: byte read strobe.
REQ-013 SHALL have port mem_wdata, output, 8 bits: byte write data.
REQ-014 SHALL have port mem_rdata, input, 8 bits: read byte, valid in the cycle after mem_re.
REQ-015 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port rsp_rdata, output, 64 bits: zero-extended load result.
REQ-017 SHALL have port stall, output, 1 bit: freeze the upstream pipeline.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE->ISSUE on req_valid.
- ISSUE->DRAIN (load) or ISSUE->DONE (store) after the last beat.
- DRAIN->DONE after one cycle.
- DONE->IDLE unconditionally.
REQ-019 SHALL assert req_ready only in IDLE, and SHALL latch all req_* inputs at acceptance.
REQ-020 SHALL use the beat count N = 1 (byte), 4 (word) or 8 (double).
REQ-021 SHALL set the start address to req_addr+3 (byte), req_addr (word) or req_addr-4 (double), with addresses ascending one per beat, modulo 1024 (wrap 1023->0, 0-4 -> 1020).
REQ-022 SHALL, on a store, drive mem_we=1 for each of the N ISSUE cycles, sending the most significant active byte first: req_wdata[8N-1:8N-8] at the start address and req_wdata[7:0] at the last address.
REQ-023 SHALL, on a load, drive mem_re=1 for each of the N ISSUE cycles, and SHALL shift each returned byte in the following cycle into the result: result <= {result[55:0], mem_rdata}.
REQ-024 SHALL clear the result register at acceptance so that byte and word loads are zero-extended.
REQ-025 SHALL hold mem_we, mem_re and mem_wdata at 0, and mem_addr at its last value, outside ISSUE.
REQ-026 SHALL pulse rsp_valid for exactly one cycle in DONE, with rsp_rdata equal to the result for loads and 0 for stores; rsp_rdata SHALL hold its value until the next acceptance.
REQ-027 SHALL meet this latency from the acceptance edge: store rsp_valid in cycle N+1; load rsp_valid in cycle N+2.
REQ-028 SHALL drive stall = (state==IDLE && req_valid) || state==ISSUE || state==DRAIN, so that stall is low in DONE and the pipeline advances with the response.
REQ-029 SHALL treat req_valid in DONE as ignored; the request is accepted in the following IDLE cycle.
REQ-030 SHALL treat req_byte=req_double=1 as a byte access.

Reset
REQ-031 SHALL, on rst, go to IDLE with these output values: req_ready=1, mem_we=0, mem_re=0, mem_wdata=0, mem_addr=0, rsp_valid=0, rsp_rdata=0, stall=0 (stall rises combinationally if req_valid is high).
REQ-032 SHALL, on rst mid-access, abort immediately with no further strobes and no rsp_valid; bytes already written stay in memory.

Structure
REQ-033 SHALL place these items in package mem_access_pkg: the state enum, ADDR_W=10, BEATS_BYTE=1, BEATS_WORD=4, BEATS_DOUBLE=8.
REQ-034 SHALL be a single module with no sub-module; the bench supplies a 1024x8 memory model mem_byte_model with a one-cycle read.

Verification
REQ-035 SHALL cover a word load: addr=0x010, memory bytes 16..19 = 00,00,00,14 -> mem_re at addresses 16,17,18,19; rsp_rdata=0x14 in cycle 6.
REQ-036 SHALL cover a double store: addr=0x008, wdata=0x0102030405060708 -> mem_we at addresses 4..11 with bytes 01..08; rsp_valid in cycle 9.
REQ-037 SHALL cover a byte load with both size flags set: addr=0x3FC, byte 1023=0xAB -> single read at address 1023; rsp_rdata=0xAB in cycle 3.
REQ-038 SHALL cover a double load with wrap: addr=0x002 -> reads at addresses 1022,1023,0,1,2,3,4,5 in that order.
REQ-039 SHALL cover a back-to-back store then load at the same address: the load returns the stored word, and stall is low only in the DONE cycles.
REQ-040 SHALL cover rst asserted during the third beat of a double store: no strobes after the reset, rsp_valid never pulses, and the state is IDLE on the next edge.
